// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one-word lines.
// Hits respond one cycle after the request. Misses issue a single-word memory
// read and answer one cycle after the ack. A branch flush drops any owed
// response. The in-flight refill still completes and fills the line.
// Optional feature macro: ICACHE_STATS_EN adds hit/miss lookup counters.
// dbg_state_out exposes the FSM state (0 IDLE, 1 WAIT, 2 DROP) for checkers.
//
// Handshake semantics:
//   if_to_icache_en_in / icache_to_if_en_out and mem_to_icache_en_in are
//   one-cycle strobes that count only on a clock edge where rdy_in is high.
//   icache_to_mem_en_out is a level request with a stable icache_a_out. It is
//   held until the edge that samples mem_to_icache_en_in, or until reset.
module icache #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_to_icache_en_in,
    input  logic [31:0] if_a_in,
    output logic        icache_to_if_en_out,
    output logic [31:0] if_d_out,
    output logic        icache_to_mem_en_out,
    output logic [31:0] icache_a_out,
    input  logic        mem_to_icache_en_in,
    input  logic [31:0] mem_d_in,
    input  logic        clear_branch_in,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt_out,
    output logic [31:0] miss_cnt_out,
`endif
    output logic [1:0]  dbg_state_out
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               resp_en_q, resp_en_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               mem_en_q, mem_en_d;
    logic [29:0]        mem_a_q, mem_a_d;      // word address of the outstanding refill
    logic               pend_valid_q, pend_valid_d;
    logic [29:0]        pend_a_q, pend_a_d;    // word address queued while in DROP
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [31:0]        data_mem [LINES];

    logic [29:0]            lookup_a;
    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic                   lookup_req;
    logic                   hit;
    logic                   ack;
    logic                   fill_we;
    logic                   unused_addr_bits;

    // A queued pending lookup takes the place of a fresh request.
    assign lookup_a   = pend_valid_q ? pend_a_q : if_a_in[31:2];
    assign lk_idx     = lookup_a[INDEX_WIDTH-1:0];
    assign lk_tag     = lookup_a[29:INDEX_WIDTH];
    assign lookup_req = rdy_in && (state_q == ST_IDLE) && !clear_branch_in
                        && (pend_valid_q || if_to_icache_en_in);
    assign hit        = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign ack        = rdy_in && mem_en_q && mem_to_icache_en_in;
    assign fill_we    = ack;
    assign fill_idx   = mem_a_q[INDEX_WIDTH-1:0];
    assign fill_tag   = mem_a_q[29:INDEX_WIDTH];
    assign unused_addr_bits = ^if_a_in[1:0];

    assign icache_to_if_en_out  = resp_en_q;
    assign if_d_out             = resp_data_q;
    assign icache_to_mem_en_out = mem_en_q;
    assign icache_a_out         = {mem_a_q, 2'b00};
    assign dbg_state_out        = state_q;

    // State and control registers; reset wins, rdy_in gating lives in the comb logic.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            resp_en_q    <= 1'b0;
            resp_data_q  <= 32'h0;
            mem_en_q     <= 1'b0;
            mem_a_q      <= 30'h0;
            pend_valid_q <= 1'b0;
            pend_a_q     <= 30'h0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_en_q    <= resp_en_d;
            resp_data_q  <= resp_data_d;
            mem_en_q     <= mem_en_d;
            mem_a_q      <= mem_a_d;
            pend_valid_q <= pend_valid_d;
            pend_a_q     <= pend_a_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data arrays are written only by refills. Validity is tracked separately.
    always_ff @(posedge clk_in) begin
        if (rst_in && fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_d_in;
        end
    end

    // Next-state logic. A flush still turns WAIT into DROP while the cache is stalled.
    always_comb begin
        state_d = state_q;
        if (!rdy_in) begin
            if (clear_branch_in && state_q == ST_WAIT) state_d = ST_DROP;
        end else begin
            unique case (state_q)
                ST_IDLE: if (lookup_req && !hit) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (ack)                  state_d = ST_IDLE;
                    else if (clear_branch_in) state_d = ST_DROP;
                end
                ST_DROP: if (ack) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values: responses, refill request, pending slot, valid bits.
    always_comb begin
        resp_en_d    = rdy_in ? 1'b0 : resp_en_q;
        resp_data_d  = resp_data_q;
        mem_en_d     = mem_en_q;
        mem_a_d      = mem_a_q;
        pend_valid_d = pend_valid_q;
        pend_a_d     = pend_a_q;
        valid_d      = valid_q;

        if (rdy_in && state_q == ST_DROP && if_to_icache_en_in && !clear_branch_in) begin
            pend_valid_d = 1'b1;
            pend_a_d     = if_a_in[31:2];
        end

        if (lookup_req) begin
            pend_valid_d = 1'b0;
            if (hit) begin
                resp_en_d   = 1'b1;
                resp_data_d = data_mem[lk_idx];
            end else begin
                mem_en_d = 1'b1;
                mem_a_d  = lookup_a;
            end
        end

        if (ack) begin
            mem_en_d          = 1'b0;
            valid_d[fill_idx] = 1'b1;
            if (state_q == ST_WAIT && !clear_branch_in) begin
                resp_en_d   = 1'b1;
                resp_data_d = mem_d_in;
            end
        end

        // A flush cancels any owed response and any queued lookup, stalled or not.
        if (clear_branch_in) begin
            resp_en_d    = 1'b0;
            pend_valid_d = 1'b0;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign hit_cnt_out  = hit_cnt_q;
    assign miss_cnt_out = miss_cnt_q;

    // Count each resolved lookup, whether fresh or pending. DROP fills never count.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_req && hit)  hit_cnt_d  = hit_cnt_q + 32'd1;
        if (lookup_req && !hit) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache (INDEX_WIDTH = 8).
// Covers cold miss and hit, conflict eviction, flush during WAIT with and without
// a pending request, a request during a flush, stall, and reset mid-miss.
// Stats checks are included when ICACHE_STATS_EN is defined.
module tb_icache;
    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        if_en;
    logic [31:0] if_a;
    logic        resp_en;
    logic [31:0] if_d;
    logic        mem_en;
    logic [31:0] mem_a;
    logic        mem_ack;
    logic [31:0] mem_d;
    logic        clear;
    logic [1:0]  dbg_state;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks_total  = 0;
    int checks_passed = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DROP = 2'd2;

    icache #(.INDEX_WIDTH(8)) dut (
        .clk_in               (clk),
        .rst_in               (rst_n),
        .rdy_in               (rdy),
        .if_to_icache_en_in   (if_en),
        .if_a_in              (if_a),
        .icache_to_if_en_out  (resp_en),
        .if_d_out             (if_d),
        .icache_to_mem_en_out (mem_en),
        .icache_a_out         (mem_a),
        .mem_to_icache_en_in  (mem_ack),
        .mem_d_in             (mem_d),
        .clear_branch_in      (clear),
`ifdef ICACHE_STATS_EN
        .hit_cnt_out          (hit_cnt),
        .miss_cnt_out         (miss_cnt),
`endif
        .dbg_state_out        (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr);
        if_en = 1'b1;
        if_a  = addr;
        cyc();
        if_en = 1'b0;
    endtask

    task automatic mem_ack_word(input logic [31:0] data);
        mem_ack = 1'b1;
        mem_d   = data;
        cyc();
        mem_ack = 1'b0;
    endtask

    task automatic flush();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    // Scoreboard: every IF response must match the oldest expected word.
    always @(posedge clk) begin
        logic [31:0] exp_d;
        #3;
        if (rst_n && resp_en) begin
            check("resp_owed", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_d = exp_q.pop_front();
                check("resp_data", if_d, exp_d);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; if_en = 1'b0; if_a = 32'h0;
        mem_ack = 1'b0; mem_d = 32'h0; clear = 1'b0;
        repeat (3) cyc();
        check("rst_resp_en", 32'(resp_en), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_if_d", if_d, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        cyc();

        // Cold miss then hit.
        fetch(32'h0000_0000);
        check("cold_mem_en", 32'(mem_en), 32'd1);
        check("cold_mem_a", mem_a, 32'h0);
        check("cold_no_resp", 32'(resp_en), 32'd0);
        cyc(); cyc();
        check("cold_mem_held", 32'(mem_en), 32'd1);
        exp_q.push_back(32'h0000_0013);
        mem_ack_word(32'h0000_0013);
        check("cold_resp_en", 32'(resp_en), 32'd1);
        check("cold_mem_drop", 32'(mem_en), 32'd0);
        cyc();
        check("cold_pulse", 32'(resp_en), 32'd0);
        exp_q.push_back(32'h0000_0013);
        fetch(32'h0000_0003);    // low bits ignored
        check("hit_resp_en", 32'(resp_en), 32'd1);
        check("hit_no_mem", 32'(mem_en), 32'd0);
        cyc();
`ifdef ICACHE_STATS_EN
        check("stats_hit", hit_cnt, 32'd1);
        check("stats_miss", miss_cnt, 32'd1);
`endif

        // Conflict eviction on index 2: 0x008, 0x408, 0x008.
        fetch(32'h0000_0008);
        check("conf1_mem_a", mem_a, 32'h0000_0008);
        exp_q.push_back(32'h1111_0008);
        mem_ack_word(32'h1111_0008);
        check("conf1_resp", 32'(resp_en), 32'd1);
        cyc();
        fetch(32'h0000_0408);
        check("conf2_miss", 32'(mem_en), 32'd1);
        check("conf2_mem_a", mem_a, 32'h0000_0408);
        exp_q.push_back(32'h2222_0408);
        mem_ack_word(32'h2222_0408);
        cyc();
        fetch(32'h0000_0008);
        check("conf3_miss", 32'(mem_en), 32'd1);
        check("conf3_mem_a", mem_a, 32'h0000_0008);
        exp_q.push_back(32'h3333_0008);
        mem_ack_word(32'h3333_0008);
        cyc();

        // Flush during WAIT with a follow-up request queued in DROP.
        fetch(32'h0000_0100);
        cyc();
        flush();
        fetch(32'h0000_0100);
        check("drop_state", 32'(dbg_state), 32'(S_DROP));
        check("drop_mem_held", 32'(mem_en), 32'd1);
        exp_q.push_back(32'hDEAD_BEEF);
        mem_ack_word(32'hDEAD_BEEF);
        check("drop_no_resp", 32'(resp_en), 32'd0);
        cyc();
        check("pend_hit_resp", 32'(resp_en), 32'd1);
        check("pend_no_mem", 32'(mem_en), 32'd0);
        cyc();

        // Flush with nothing pending.
        fetch(32'h0000_0200);
        flush();
        check("drop2_state", 32'(dbg_state), 32'(S_DROP));
        cyc();
        check("drop2_mem_held", 32'(mem_en), 32'd1);
        mem_ack_word(32'h5555_0200);
        check("drop2_no_resp", 32'(resp_en), 32'd0);
        check("drop2_idle", 32'(dbg_state), 32'(S_IDLE));
        cyc();
        exp_q.push_back(32'h5555_0200);
        fetch(32'h0000_0200);
        check("drop2_hit", 32'(resp_en), 32'd1);
        cyc();

        // A request in the same cycle as a flush is ignored.
        clear = 1'b1;
        fetch(32'h0000_0200);
        clear = 1'b0;
        check("clr_req_no_resp", 32'(resp_en), 32'd0);
        check("clr_req_no_mem", 32'(mem_en), 32'd0);
        cyc();

        // Stall: request held during 3 cycles of rdy low, then accepted.
        rdy   = 1'b0;
        if_en = 1'b1;
        if_a  = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_no_resp", 32'(resp_en), 32'd0);
        end
        rdy = 1'b1;
        exp_q.push_back(32'h0000_0013);
        cyc();
        if_en = 1'b0;
        check("stall_resp", 32'(resp_en), 32'd1);
        cyc();

        // Reset in the middle of a miss.
        fetch(32'h0000_0300);
        check("rstw_mem_en", 32'(mem_en), 32'd1);
        cyc();
        rst_n = 1'b0;
        cyc();
        check("rstw_mem_drop", 32'(mem_en), 32'd0);
        check("rstw_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        cyc();
        fetch(32'h0000_0000);
        check("rstw_cold_miss", 32'(mem_en), 32'd1);
        check("rstw_no_resp", 32'(resp_en), 32'd0);
        exp_q.push_back(32'h0000_0077);
        mem_ack_word(32'h0000_0077);
        check("rstw_resp", 32'(resp_en), 32'd1);
        cyc();
`ifdef ICACHE_STATS_EN
        check("stats_rst_hit", hit_cnt, 32'd0);
        check("stats_rst_miss", miss_cnt, 32'd1);
`endif
        cyc();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // Final report.
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
